ipdc_host_ctrl: RTL and testbench
=================================

// Module: ipdc_host_ctrl
// PURPOSE
//  Host-side initiator for the ipdc op/in/out handshakes. Takes one command from upstream,
//  waits for o_op_ready from ipdc and issues the op. LOAD streams N_PIX pixels from a sync pixel ROM.
//  Other modes collect ipdc output beats until ipdc signals ready again.
//  Sits between sequencer/testbench and u_ipdc; ports mirror ipdc with directions reversed.
// PARAMETERS
//  N_PIX    256    pixels streamed per LOAD op (16x16 image)
//  DW       24     pixel width (8b R/G/B)
//  TIMEOUT  4096   max cycles waiting for op_ready (WAIT_RDY, DRAIN) before error abort
// PORTS
//  i_clk         in   1    clock, rising edge
//  i_rst         in   1    synchronous active-high reset
//  i_cmd_valid   in   1    upstream command valid
//  i_cmd_mode    in   4    op code; 4'b0000 = LOAD, others = non-load ops
//  o_cmd_ready   out  1    high in IDLE only; cmd accepted when valid&ready
//  o_pix_addr    out  8    pixel ROM address; data returns on i_pix_data next cycle
//  i_pix_data    in   DW   pixel ROM read data (1-cycle latency)
//  i_op_ready    in   1    ipdc o_op_ready
//  o_op_valid    out  1    ipdc i_op_valid, one-cycle pulse
//  o_op_mode     out  4    ipdc i_op_mode, valid with o_op_valid
//  o_in_valid    out  1    ipdc i_in_valid
//  o_in_data     out  DW   ipdc i_in_data
//  i_in_ready    in   1    ipdc o_in_ready
//  i_out_valid   in   1    ipdc o_out_valid
//  i_out_data    in   DW   ipdc o_out_data
//  o_res_valid   out  1    registered copy of i_out_valid (DRAIN only)
//  o_res_data    out  DW   registered copy of i_out_data
//  o_done        out  1    one-cycle pulse at op completion
//  o_out_cnt     out  11   beats collected for last op; held until next cmd accept
//  o_err         out  1    one-cycle pulse on timeout abort
//  o_chksum      out  DW   running XOR of result beats (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (o_cmd_ready=1 on first post-reset cycle); counters cleared.
//  FSM: IDLE -> WAIT_RDY on cmd accept (mode latched, o_out_cnt and timeout cleared).
//   WAIT_RDY: i_op_ready=1 -> ISSUE. Timeout hit -> o_err pulse, IDLE.
//   ISSUE: o_op_valid=1 and o_op_mode=latched for exactly 1 cycle; then LOAD if mode==0, else DRAIN.
//   LOAD: o_in_valid/o_in_data from ROM addr 0..N_PIX-1 in order.
//    Beat transfers when o_in_valid&i_in_ready. Unaccepted data held stable.
//    Needs 2-entry skid for ROM latency; no beat dropped or duplicated.
//    i_in_ready=1 every cycle -> one beat per cycle, first beat <=2 cycles after ISSUE.
//    After beat N_PIX-1 -> DONE.
//   DRAIN: every i_out_valid beat -> o_res_valid/o_res_data next cycle, o_out_cnt+1 (saturate 2047).
//    i_op_ready=1 -> DONE; beat in same cycle is still counted. Timeout -> o_err, IDLE.
//   DONE: o_done=1 for 1 cycle; -> IDLE.
//  o_op_valid only ever asserted in ISSUE; never two ops without intervening i_op_ready.
//  i_out_valid outside DRAIN is ignored (not counted, not forwarded).
//  i_cmd_valid while not IDLE: ignored, o_cmd_ready=0, cmd stays pending upstream.
//  Timeout counter resets on each state entry; abort when it reaches TIMEOUT-1.
//  i_rst mid-op: next cycle IDLE, o_in_valid/o_op_valid=0 immediately; partial load abandoned.
// CONFIGURATION
//  IPDC_HOST_CHKSUM_EN defined: o_chksum = XOR of all o_res_data beats of current op.
//   Cleared on cmd accept; held after o_done.
//  Not defined: o_chksum tied to 0, no XOR logic synthesized.
// TESTING
//  LOAD, i_in_ready=1, ROM[a]={a,a,a} -> 256 beats data 0x000000..0xFFFFFF step 0x010101,
//   o_done at end, no gaps.
//  LOAD, i_in_ready toggling 1,0,1,0 -> same 256-beat sequence, data stable while ready=0, none lost.
//  mode 4'b0001, ipdc gives 16 out beats then op_ready -> o_out_cnt=16, 16 o_res beats, one o_done.
//  i_op_ready held 0 with TIMEOUT=16 -> o_err pulse 16 cycles after WAIT_RDY entry, back to IDLE.
//  i_rst at LOAD beat 100 -> o_in_valid=0 next cycle, IDLE; new LOAD restarts at addr 0.
//  CHKSUM_EN, out beats 0x123456,0x654321 -> o_chksum=0x777777; undefined -> 0.

Source files
------------

// File: rtl/ipdc_host_ctrl.sv
// ipdc_host_ctrl: host-side initiator for the ipdc op/in/out handshakes.
// It takes one upstream command, waits for ipdc op_ready, and issues the op.
// A LOAD op streams N_PIX pixels from a synchronous ROM through a two-entry
// skid buffer. Any other op collects ipdc result beats until op_ready returns.
// Optional feature macro: IPDC_HOST_CHKSUM_EN puts a running XOR of the
// current op's result beats on o_chksum. Without the macro, o_chksum is 0.
module ipdc_host_ctrl #(
    parameter int N_PIX   = 256,
    parameter int DW      = 24,
    parameter int TIMEOUT = 4096
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    input  logic [3:0]    i_cmd_mode,
    output logic          o_cmd_ready,
    output logic [7:0]    o_pix_addr,
    input  logic [DW-1:0] i_pix_data,
    input  logic          i_op_ready,
    output logic          o_op_valid,
    output logic [3:0]    o_op_mode,
    output logic          o_in_valid,
    output logic [DW-1:0] o_in_data,
    input  logic          i_in_ready,
    input  logic          i_out_valid,
    input  logic [DW-1:0] i_out_data,
    output logic          o_res_valid,
    output logic [DW-1:0] o_res_data,
    output logic          o_done,
    output logic [10:0]   o_out_cnt,
    output logic          o_err,
    output logic [DW-1:0] o_chksum
);
    localparam int CW = $clog2(N_PIX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] NPIX_C    = CW'(N_PIX);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_PIX - 1);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);
    localparam logic [3:0]    MODE_LOAD = 4'b0000;
    localparam logic [10:0]   CNT_MAX   = 11'd2047;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_ISSUE    = 3'd2,
        S_LOAD     = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t        state_q;
    logic [3:0]    mode_q;
    logic          cmd_ready_q;
    logic          op_valid_q;
    logic [3:0]    op_mode_q;
    logic          in_valid_q;
    logic [DW-1:0] in_data_q;
    logic          skid_valid_q;
    logic [DW-1:0] skid_data_q;
    logic          rom_vld_q;
    logic [7:0]    pix_addr_q;
    logic [CW-1:0] issued_q;
    logic [CW-1:0] acc_q;
    logic [TW-1:0] tmo_q;
    logic          res_valid_q;
    logic [DW-1:0] res_data_q;
    logic [10:0]   out_cnt_q;
    logic          done_q;
    logic          err_q;
`ifdef IPDC_HOST_CHKSUM_EN
    logic [DW-1:0] chksum_q;
`endif

    logic          pop_s;
    logic [1:0]    held_s;
    logic          load_phase_s;
    logic          rd_fire_s;
    logic          in_valid_d;
    logic [DW-1:0] in_data_d;
    logic          skid_valid_d;
    logic [DW-1:0] skid_data_d;

    // Skid buffer next-state and ROM read credit: a read fires only when the
    // buffer can absorb its data even if the sink stalls the next cycle.
    always_comb begin
        pop_s        = in_valid_q & i_in_ready;
        held_s       = {1'b0, in_valid_q} + {1'b0, skid_valid_q} - {1'b0, pop_s};
        load_phase_s = (state_q == S_LOAD) || ((state_q == S_ISSUE) && (mode_q == MODE_LOAD));
        rd_fire_s    = load_phase_s && (issued_q < NPIX_C) &&
                       ((held_s + {1'b0, rom_vld_q}) < 2'd2);
        in_valid_d   = in_valid_q;
        in_data_d    = in_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (pop_s) begin
            if (skid_valid_q) begin
                in_valid_d = 1'b1;
                in_data_d  = skid_data_q;
                if (rom_vld_q) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = i_pix_data;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (rom_vld_q) begin
                in_valid_d   = 1'b1;
                in_data_d    = i_pix_data;
                skid_valid_d = 1'b0;
            end else begin
                in_valid_d   = 1'b0;
                skid_valid_d = 1'b0;
            end
        end else if (!in_valid_q) begin
            if (rom_vld_q) begin
                in_valid_d = 1'b1;
                in_data_d  = i_pix_data;
            end else begin
                in_valid_d = 1'b0;
            end
        end else if (rom_vld_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_pix_data;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Control FSM, LOAD streaming, DRAIN capture and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 4'b0000;
            cmd_ready_q  <= 1'b1;
            op_valid_q   <= 1'b0;
            op_mode_q    <= 4'b0000;
            in_valid_q   <= 1'b0;
            in_data_q    <= {DW{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DW{1'b0}};
            rom_vld_q    <= 1'b0;
            pix_addr_q   <= 8'd0;
            issued_q     <= {CW{1'b0}};
            acc_q        <= {CW{1'b0}};
            tmo_q        <= {TW{1'b0}};
            res_valid_q  <= 1'b0;
            res_data_q   <= {DW{1'b0}};
            out_cnt_q    <= 11'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef IPDC_HOST_CHKSUM_EN
            chksum_q     <= {DW{1'b0}};
`endif
        end else begin
            op_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            in_valid_q   <= in_valid_d;
            in_data_q    <= in_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            rom_vld_q    <= rd_fire_s;
            if (rd_fire_s) begin
                pix_addr_q <= pix_addr_q + 8'd1;
                issued_q   <= issued_q + ONE_C;
            end else begin
                pix_addr_q <= pix_addr_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_cmd_valid && cmd_ready_q) begin
                        mode_q      <= i_cmd_mode;
                        out_cnt_q   <= 11'd0;
                        tmo_q       <= {TW{1'b0}};
                        pix_addr_q  <= 8'd0;
                        issued_q    <= {CW{1'b0}};
                        acc_q       <= {CW{1'b0}};
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_WAIT_RDY;
`ifdef IPDC_HOST_CHKSUM_EN
                        chksum_q    <= {DW{1'b0}};
`endif
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (i_op_ready) begin
                        op_valid_q <= 1'b1;
                        op_mode_q  <= mode_q;
                        tmo_q      <= {TW{1'b0}};
                        state_q    <= S_ISSUE;
                    end else if (tmo_q == TMO_MAX) begin
                        err_q       <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                S_ISSUE: begin
                    tmo_q <= {TW{1'b0}};
                    if (mode_q == MODE_LOAD) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_LOAD: begin
                    if (pop_s) begin
                        acc_q <= acc_q + ONE_C;
                        if (acc_q == LAST_BEAT) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (i_out_valid) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= i_out_data;
`ifdef IPDC_HOST_CHKSUM_EN
                        chksum_q    <= chksum_q ^ i_out_data;
`endif
                        if (out_cnt_q != CNT_MAX) begin
                            out_cnt_q <= out_cnt_q + 11'd1;
                        end else begin
                            out_cnt_q <= out_cnt_q;
                        end
                    end else begin
                        res_data_q <= res_data_q;
                    end
                    if (i_op_ready) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (tmo_q == TMO_MAX) begin
                        err_q       <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                S_DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_pix_addr  = pix_addr_q;
    assign o_op_valid  = op_valid_q;
    assign o_op_mode   = op_mode_q;
    assign o_in_valid  = in_valid_q;
    assign o_in_data   = in_data_q;
    assign o_res_valid = res_valid_q;
    assign o_res_data  = res_data_q;
    assign o_done      = done_q;
    assign o_out_cnt   = out_cnt_q;
    assign o_err       = err_q;
`ifdef IPDC_HOST_CHKSUM_EN
    assign o_chksum    = chksum_q;
`else
    assign o_chksum    = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_ipdc_host_ctrl.sv
// Self-checking bench for ipdc_host_ctrl: ROM model, ipdc-side stimulus and
// queue scoreboards for streamed pixels and forwarded result beats.
module tb_ipdc_host_ctrl;
    localparam int N_PIX   = 256;
    localparam int DW      = 24;
    localparam int TIMEOUT = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic [3:0]    i_cmd_mode = 4'b0000;
    logic          o_cmd_ready;
    logic [7:0]    o_pix_addr;
    logic [DW-1:0] i_pix_data = {DW{1'b0}};
    logic          i_op_ready = 1'b0;
    logic          o_op_valid;
    logic [3:0]    o_op_mode;
    logic          o_in_valid;
    logic [DW-1:0] o_in_data;
    logic          i_in_ready = 1'b0;
    logic          i_out_valid = 1'b0;
    logic [DW-1:0] i_out_data = {DW{1'b0}};
    logic          o_res_valid;
    logic [DW-1:0] o_res_data;
    logic          o_done;
    logic [10:0]   o_out_cnt;
    logic          o_err;
    logic [DW-1:0] o_chksum;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] res_obs[$];
    int            d_ndone, d_nerr, d_nop;
    logic [3:0]    d_mode;
    logic [10:0]   d_cnt;
    logic [DW-1:0] d_chk;

    ipdc_host_ctrl #(.N_PIX(N_PIX), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .i_cmd_mode(i_cmd_mode), .o_cmd_ready(o_cmd_ready),
        .o_pix_addr(o_pix_addr), .i_pix_data(i_pix_data),
        .i_op_ready(i_op_ready), .o_op_valid(o_op_valid), .o_op_mode(o_op_mode),
        .o_in_valid(o_in_valid), .o_in_data(o_in_data), .i_in_ready(i_in_ready),
        .i_out_valid(i_out_valid), .i_out_data(i_out_data),
        .o_res_valid(o_res_valid), .o_res_data(o_res_data),
        .o_done(o_done), .o_out_cnt(o_out_cnt), .o_err(o_err), .o_chksum(o_chksum)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous pixel ROM: ROM[a] = {a,a,a}, one-cycle read latency
    always @(posedge i_clk) i_pix_data <= {o_pix_addr, o_pix_addr, o_pix_addr};

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [3:0] mode);
        int n;
        n = 0;
        while (o_cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_wait: got %b want 1", o_cmd_ready);
        end
        i_cmd_valid = 1'b1;
        i_cmd_mode  = mode;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({o_op_valid, o_in_valid, o_done, o_err, o_res_valid} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000", {o_op_valid, o_in_valid, o_done, o_err, o_res_valid});
        end
        checks++;
        if (o_out_cnt !== 11'd0) begin
            failures++;
            $display("FAIL reset_out_cnt: got %0d want 0", o_out_cnt);
        end
        checks++;
        if (o_chksum !== 24'h000000 || o_pix_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs: chksum %h addr %h want 0", o_chksum, o_pix_addr);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready);
        end
    endtask

    task automatic test_load(input bit toggle);
        int cyc, beats, issue_cyc, first_cyc, last_cyc, done_cyc, ndone, nop, gaps;
        bit held;
        logic [DW-1:0] held_d;
        logic [DW-1:0] expv;
        cyc = 0; beats = 0; issue_cyc = -1; first_cyc = -1; last_cyc = -1;
        done_cyc = -1; ndone = 0; nop = 0; gaps = 0; held = 1'b0; held_d = '0;
        exp_q.delete();
        for (int a = 0; a < N_PIX; a++) exp_q.push_back({a[7:0], a[7:0], a[7:0]});
        i_op_ready = 1'b1;
        i_in_ready = 1'b0;
        issue_cmd(4'b0000);
        while (cyc < 2 * N_PIX + 40) begin
            if (o_op_valid === 1'b1) begin
                nop++;
                issue_cyc = cyc;
                i_op_ready = 1'b0;
                checks++;
                if (o_op_mode !== 4'b0000) begin
                    failures++;
                    $display("FAIL load_op_mode: got %h want 0", o_op_mode);
                end
            end
            if (o_done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
            i_in_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (o_in_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (held) begin
                    checks++;
                    if (o_in_data !== held_d) begin
                        failures++;
                        $display("FAIL load_hold: got %h want %h", o_in_data, held_d);
                    end
                end
                if (i_in_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL load_extra_beat: got %h want none", o_in_data);
                    end else begin
                        expv = exp_q.pop_front();
                        if (o_in_data !== expv) begin
                            failures++;
                            $display("FAIL load_data: got %h want %h", o_in_data, expv);
                        end
                    end
                    beats++;
                    last_cyc = cyc;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_d = o_in_data;
                end
            end else begin
                if (held) begin
                    checks++;
                    failures++;
                    $display("FAIL load_hold_drop: got valid 0 want 1");
                    held = 1'b0;
                end
                if (first_cyc >= 0 && beats < N_PIX) gaps++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            tick();
            cyc++;
        end
        i_in_ready = 1'b0;
        checks++;
        if (beats !== N_PIX || exp_q.size() != 0) begin
            failures++;
            $display("FAIL load_count: got %0d beats want %0d (left %0d)", beats, N_PIX, exp_q.size());
        end
        checks++;
        if (nop !== 1 || ndone !== 1) begin
            failures++;
            $display("FAIL load_pulses: got op %0d done %0d want 1 1", nop, ndone);
        end
        checks++;
        if (done_cyc !== last_cyc + 1) begin
            failures++;
            $display("FAIL load_done_timing: got cyc %0d want %0d", done_cyc, last_cyc + 1);
        end
        checks++;
        if (issue_cyc < 0 || first_cyc - issue_cyc > 2 || first_cyc <= issue_cyc) begin
            failures++;
            $display("FAIL load_first_latency: got %0d want 1..2", first_cyc - issue_cyc);
        end
        if (!toggle) begin
            checks++;
            if (gaps !== 0) begin
                failures++;
                $display("FAIL load_gaps: got %0d want 0", gaps);
            end
        end
        checks++;
        if (o_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_idle_valid: got %b want 0", o_in_valid);
        end
    endtask

    task automatic observe_drain();
        if (o_res_valid === 1'b1) res_obs.push_back(o_res_data);
        if (o_done === 1'b1) d_ndone++;
        if (o_err === 1'b1) d_nerr++;
        if (o_op_valid === 1'b1) d_nop++;
    endtask

    // Drives one non-load op: n result beats, op_ready together with the last
    task automatic drain_op(input logic [3:0] mode, input int n, input bit fixed);
        int w;
        logic [DW-1:0] dv;
        exp_q.delete();
        res_obs.delete();
        d_ndone = 0; d_nerr = 0; d_nop = 0; d_mode = 4'b0000;
        i_op_ready = 1'b1;
        issue_cmd(mode);
        w = 0;
        while (o_op_valid !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        if (o_op_valid === 1'b1) begin
            d_nop++;
            d_mode = o_op_mode;
        end
        i_op_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            observe_drain();
            if (fixed) dv = (k == 0) ? 24'h123456 : 24'h654321;
            else dv = 24'($urandom);
            i_out_valid = 1'b1;
            i_out_data  = dv;
            exp_q.push_back(dv);
            i_op_ready  = (k == n - 1);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            observe_drain();
            i_out_valid = 1'b0;
            i_op_ready  = 1'b0;
        end
        d_cnt = o_out_cnt;
        d_chk = o_chksum;
    endtask

    task automatic test_drain();
        logic [DW-1:0] xr;
        logic [DW-1:0] expv;
        logic [DW-1:0] gotv;
        drain_op(4'b0001, 16, 1'b0);
        xr = '0;
        foreach (exp_q[i]) xr = xr ^ exp_q[i];
`ifndef IPDC_HOST_CHKSUM_EN
        xr = '0;
`endif
        checks++;
        if (res_obs.size() != 16) begin
            failures++;
            $display("FAIL drain_res_count: got %0d want 16", res_obs.size());
        end
        while (exp_q.size() > 0 && res_obs.size() > 0) begin
            expv = exp_q.pop_front();
            gotv = res_obs.pop_front();
            checks++;
            if (gotv !== expv) begin
                failures++;
                $display("FAIL drain_res_data: got %h want %h", gotv, expv);
            end
        end
        checks++;
        if (d_cnt !== 11'd16) begin
            failures++;
            $display("FAIL drain_out_cnt: got %0d want 16", d_cnt);
        end
        checks++;
        if (d_ndone !== 1 || d_nerr !== 0 || d_nop !== 1) begin
            failures++;
            $display("FAIL drain_pulses: got done %0d err %0d op %0d want 1 0 1", d_ndone, d_nerr, d_nop);
        end
        checks++;
        if (d_mode !== 4'b0001) begin
            failures++;
            $display("FAIL drain_op_mode: got %h want 1", d_mode);
        end
        checks++;
        if (d_chk !== xr) begin
            failures++;
            $display("FAIL drain_chksum: got %h want %h", d_chk, xr);
        end
    endtask

    task automatic test_ignore();
        logic [DW-1:0] chk0;
        chk0 = o_chksum;
        for (int k = 0; k < 4; k++) begin
            i_out_valid = 1'b1;
            i_out_data  = 24'hABCDEF;
            tick();
            checks++;
            if (o_res_valid !== 1'b0) begin
                failures++;
                $display("FAIL ignore_res_valid: got %b want 0", o_res_valid);
            end
        end
        i_out_valid = 1'b0;
        tick();
        checks++;
        if (o_out_cnt !== 11'd16 || o_chksum !== chk0) begin
            failures++;
            $display("FAIL ignore_hold: got cnt %0d chk %h want 16 %h", o_out_cnt, o_chksum, chk0);
        end
    endtask

    task automatic test_chksum();
        logic [DW-1:0] want;
`ifdef IPDC_HOST_CHKSUM_EN
        want = 24'h777777;
`else
        want = 24'h000000;
`endif
        drain_op(4'b0010, 2, 1'b1);
        checks++;
        if (d_chk !== want) begin
            failures++;
            $display("FAIL chksum_value: got %h want %h", d_chk, want);
        end
        checks++;
        if (d_cnt !== 11'd2 || res_obs.size() != 2) begin
            failures++;
            $display("FAIL chksum_beats: got cnt %0d res %0d want 2 2", d_cnt, res_obs.size());
        end
        checks++;
        if (d_ndone !== 1) begin
            failures++;
            $display("FAIL chksum_done: got %0d want 1", d_ndone);
        end
    endtask

    task automatic test_timeout();
        i_op_ready = 1'b0;
        issue_cmd(4'b0011);
        i_cmd_valid = 1'b1;
        i_cmd_mode  = 4'b0101;
        for (int j = 1; j <= 20; j++) begin
            tick();
            checks++;
            if (o_err !== (j == 16)) begin
                failures++;
                $display("FAIL timeout_err: cycle %0d got %b want %b", j, o_err, (j == 16));
            end
            checks++;
            if (o_op_valid !== 1'b0) begin
                failures++;
                $display("FAIL timeout_op_valid: cycle %0d got %b want 0", j, o_op_valid);
            end
            if (j < 16) begin
                checks++;
                if (o_cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_cmd_ready: cycle %0d got %b want 0", j, o_cmd_ready);
                end
            end
            if (j == 16) begin
                checks++;
                if (o_cmd_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL timeout_idle: got %b want 1", o_cmd_ready);
                end
                i_cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int beats, cyc;
        beats = 0;
        cyc = 0;
        i_op_ready = 1'b1;
        i_in_ready = 1'b1;
        issue_cmd(4'b0000);
        while (beats < 100 && cyc < 400) begin
            if (o_op_valid === 1'b1) i_op_ready = 1'b0;
            if (o_in_valid === 1'b1 && i_in_ready) beats++;
            tick();
            cyc++;
        end
        checks++;
        if (beats !== 100) begin
            failures++;
            $display("FAIL midrst_reach: got %0d beats want 100", beats);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if (o_in_valid !== 1'b0 || o_op_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_valids: got in %b op %b want 0 0", o_in_valid, o_op_valid);
        end
        checks++;
        if (o_pix_addr !== 8'd0 || o_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_idle: got addr %h rdy %b want 00 1", o_pix_addr, o_cmd_ready);
        end
        i_rst = 1'b0;
        i_in_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load(1'b0);
        test_load(1'b1);
        test_drain();
        test_ignore();
        test_chksum();
        test_timeout();
        test_reset_mid_load();
        test_load(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
